// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared state and hazard encodings for the pipeline controller
package cpu_types_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    // Listed lowest to highest priority; the encoder below picks the highest active one.
    typedef enum logic [2:0] {
        HZ_NONE     = 3'd0,
        HZ_IMISS    = 3'd1,
        HZ_LOADUSE  = 3'd2,
        HZ_BRANCH   = 3'd3,
        HZ_HALT     = 3'd4,
        HZ_DSTALL   = 3'd5
    } hazard_t;

    // A pending data access outranks everything: nothing may move while memory is busy.
    // Halt only matters once the data port is free, and a taken branch squashes
    // whatever the load-use or fetch-miss logic would otherwise hold.
    function automatic hazard_t hazard_prio(
        input logic dstall,
        input logic halt_req,
        input logic branch,
        input logic load_use,
        input logic imiss
    );
        if (dstall)        return HZ_DSTALL;
        else if (halt_req) return HZ_HALT;
        else if (branch)   return HZ_BRANCH;
        else if (load_use) return HZ_LOADUSE;
        else if (imiss)    return HZ_IMISS;
        else               return HZ_NONE;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard detection between ID/EX and IF/ID
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic                  mem_to_reg_i,
    input  logic [REG_ADDR_W-1:0] idex_wsel_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    output logic                  load_use_o
);

    // A load writing r0 never creates a dependency, since r0 reads as zero.
    assign load_use_o = mem_to_reg_i
                      & (idex_wsel_i != '0)
                      & ((idex_wsel_i == ifid_rs_i) | (idex_wsel_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall, flush and halt control for a five-stage pipeline
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ihit,
    input  logic                  dhit,
    input  logic                  memcuDRE,
    input  logic                  memcuDWE,
    input  logic                  memcuHALT,
    input  logic                  idexMemToReg,
    input  logic [REG_ADDR_W-1:0] idexwsel,
    input  logic [REG_ADDR_W-1:0] ifidrs,
    input  logic [REG_ADDR_W-1:0] ifidrt,
    input  logic                  exbranch,
    output logic                  ifidW,
    output logic                  ifidRST,
    output logic                  idexW,
    output logic                  idexRST,
    output logic                  exW,
    output logic                  exRST,
    output logic                  memW,
    output logic                  memRST,
    output logic                  pc_en,
    output logic                  iREN,
    output logic                  halt,
    output logic [CNT_W-1:0]      stall_cnt
);

    pc_state_t        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             dreq, dstall, load_use;
    hazard_t          hz;
    logic             ifid_w, idex_w, ex_w, mem_w;
    logic             ifid_rst, idex_rst, ex_rst, mem_rst;

    assign dreq = memcuDRE | memcuDWE;

    hazard_detect u_hazard_detect (
        .mem_to_reg_i (idexMemToReg),
        .idex_wsel_i  (idexwsel),
        .ifid_rs_i    (ifidrs),
        .ifid_rt_i    (ifidrt),
        .load_use_o   (load_use)
    );

    // Data stall is live on a fresh miss in RUN or any non-hit cycle while waiting.
    assign dstall = ((state_q == RUN) & dreq & ~dhit) | ((state_q == DWAIT) & ~dhit);
    assign hz     = hazard_prio(dstall, memcuHALT, exbranch, load_use, ~ihit);

    // Decode state and highest-priority hazard into latch enables, flushes and next state.
    // The dhit cycle of DWAIT resolves exactly like a RUN cycle, so a branch or fetch
    // miss that arrived during the wait takes effect there.
    always_comb begin
        state_d  = state_q;
        ifid_w   = 1'b0;
        idex_w   = 1'b0;
        ex_w     = 1'b0;
        mem_w    = 1'b0;
        ifid_rst = 1'b0;
        idex_rst = 1'b0;
        ex_rst   = 1'b0;
        mem_rst  = 1'b0;
        pc_en    = 1'b0;
        iREN     = 1'b0;
        halt     = 1'b0;
        if (RST) begin
            state_d  = RUN;
            ifid_rst = 1'b1;
            idex_rst = 1'b1;
            ex_rst   = 1'b1;
            mem_rst  = 1'b1;
        end else if (state_q == HALTED) begin
            halt = 1'b1;
        end else begin
            iREN    = (state_q == RUN) & ~dreq;
            state_d = RUN;
            case (hz)
                HZ_DSTALL: state_d = DWAIT;
                HZ_HALT: begin
                    mem_w   = 1'b1;
                    state_d = HALTED;
                end
                HZ_BRANCH: begin
                    ifid_rst = 1'b1;
                    idex_rst = 1'b1;
                    pc_en    = 1'b1;
                    ex_w     = 1'b1;
                    mem_w    = 1'b1;
                end
                HZ_LOADUSE: begin
                    idex_rst = 1'b1;
                    ex_w     = 1'b1;
                    mem_w    = 1'b1;
                end
                HZ_IMISS: begin
                    ifid_rst = 1'b1;
                    idex_w   = 1'b1;
                    ex_w     = 1'b1;
                    mem_w    = 1'b1;
                end
                default: begin
                    ifid_w = 1'b1;
                    idex_w = 1'b1;
                    ex_w   = 1'b1;
                    mem_w  = 1'b1;
                    pc_en  = 1'b1;
                end
            endcase
        end
    end

    // A flush always wins over a latch enable on the same register.
    assign ifidW   = ifid_w & ~ifid_rst;
    assign idexW   = idex_w & ~idex_rst;
    assign exW     = ex_w   & ~ex_rst;
    assign memW    = mem_w  & ~mem_rst;
    assign ifidRST = ifid_rst;
    assign idexRST = idex_rst;
    assign exRST   = ex_rst;
    assign memRST  = mem_rst;

    // Advance the FSM and count non-halted cycles in which EX/MEM did not advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q != HALTED) && !exW && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, ihit, dhit, memcuDRE, memcuDWE, memcuHALT, idexMemToReg, exbranch;
    logic [4:0] idexwsel, ifidrs, ifidrt;
    logic       ifidW, ifidRST, idexW, idexRST, exW, exRST, memW, memRST, pc_en, iREN, halt;
    logic [31:0] stall_cnt;
    logic       s_ifidW, s_ifidRST, s_idexW, s_idexRST, s_exW, s_exRST, s_memW, s_memRST;
    logic       s_pc_en, s_iREN, s_halt;
    logic [3:0] s_stall_cnt;

    int compared = 0;
    int mismatched = 0;

    wire [3:0] w_vec = {ifidW, idexW, exW, memW};
    wire [3:0] r_vec = {ifidRST, idexRST, exRST, memRST};

    pipeline_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
        .idexMemToReg(idexMemToReg), .idexwsel(idexwsel), .ifidrs(ifidrs), .ifidrt(ifidrt),
        .exbranch(exbranch),
        .ifidW(ifidW), .ifidRST(ifidRST), .idexW(idexW), .idexRST(idexRST),
        .exW(exW), .exRST(exRST), .memW(memW), .memRST(memRST),
        .pc_en(pc_en), .iREN(iREN), .halt(halt), .stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
        .idexMemToReg(idexMemToReg), .idexwsel(idexwsel), .ifidrs(ifidrs), .ifidrt(ifidrt),
        .exbranch(exbranch),
        .ifidW(s_ifidW), .ifidRST(s_ifidRST), .idexW(s_idexW), .idexRST(s_idexRST),
        .exW(s_exW), .exRST(s_exRST), .memW(s_memW), .memRST(s_memRST),
        .pc_en(s_pc_en), .iREN(s_iREN), .halt(s_halt), .stall_cnt(s_stall_cnt)
    );

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; memcuDRE = 1'b0; memcuDWE = 1'b0; memcuHALT = 1'b0;
        idexMemToReg = 1'b0; idexwsel = 5'd0; ifidrs = 5'd0; ifidrt = 5'd0; exbranch = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle();
        next_cycle();
        #1;
        compared++; if (w_vec !== 4'b0000) begin mismatched++; $display("FAIL reset_w: got %b want 0000", w_vec); end
        compared++; if (r_vec !== 4'b1111) begin mismatched++; $display("FAIL reset_rst: got %b want 1111", r_vec); end
        compared++; if (pc_en !== 1'b0) begin mismatched++; $display("FAIL reset_pc_en: got %b want 0", pc_en); end
        compared++; if (halt !== 1'b0) begin mismatched++; $display("FAIL reset_halt: got %b want 0", halt); end
        compared++; if (stall_cnt !== 32'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        RST = 1'b0;
    endtask

    task automatic test_normal();
        idle();
        #1;
        compared++; if (w_vec !== 4'b1111) begin mismatched++; $display("FAIL normal_w: got %b want 1111", w_vec); end
        compared++; if (r_vec !== 4'b0000) begin mismatched++; $display("FAIL normal_rst: got %b want 0000", r_vec); end
        compared++; if ({pc_en, iREN} !== 2'b11) begin mismatched++; $display("FAIL normal_pc_iren: got %b want 11", {pc_en, iREN}); end
        next_cycle();
        compared++; if (stall_cnt !== 32'd0) begin mismatched++; $display("FAIL normal_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_data_stall();
        idle();
        memcuDRE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++; if (w_vec !== 4'b0000) begin mismatched++; $display("FAIL dstall_w[%0d]: got %b want 0000", i, w_vec); end
            compared++; if ({pc_en, iREN} !== 2'b00) begin mismatched++; $display("FAIL dstall_pc_iren[%0d]: got %b want 00", i, {pc_en, iREN}); end
            next_cycle();
        end
        dhit = 1'b1;
        #1;
        compared++; if (stall_cnt !== 32'd3) begin mismatched++; $display("FAIL dstall_cnt: got %0d want 3", stall_cnt); end
        compared++; if (w_vec !== 4'b1111) begin mismatched++; $display("FAIL dstall_hit_w: got %b want 1111", w_vec); end
        compared++; if ({pc_en, iREN} !== 2'b10) begin mismatched++; $display("FAIL dstall_hit_pc_iren: got %b want 10", {pc_en, iREN}); end
        next_cycle();
        idle();
        #1;
        compared++; if ({w_vec, iREN} !== 5'b11111) begin mismatched++; $display("FAIL dstall_after: got %b want 11111", {w_vec, iREN}); end
        next_cycle();
        compared++; if (stall_cnt !== 32'd3) begin mismatched++; $display("FAIL dstall_cnt_after: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_load_use();
        idle();
        idexMemToReg = 1'b1; idexwsel = 5'd5; ifidrt = 5'd5; ifidrs = 5'd2;
        #1;
        compared++; if (w_vec !== 4'b0011) begin mismatched++; $display("FAIL lu_rt_w: got %b want 0011", w_vec); end
        compared++; if (r_vec !== 4'b0100) begin mismatched++; $display("FAIL lu_rt_rst: got %b want 0100", r_vec); end
        compared++; if (pc_en !== 1'b0) begin mismatched++; $display("FAIL lu_rt_pc_en: got %b want 0", pc_en); end
        next_cycle();
        idexMemToReg = 1'b0;
        #1;
        compared++; if ({w_vec, r_vec, pc_en} !== 9'b1111_0000_1) begin mismatched++; $display("FAIL lu_release: got %b want 111100001", {w_vec, r_vec, pc_en}); end
        next_cycle();
        idexMemToReg = 1'b1; idexwsel = 5'd0; ifidrt = 5'd0; ifidrs = 5'd0;
        #1;
        compared++; if ({w_vec, r_vec, pc_en} !== 9'b1111_0000_1) begin mismatched++; $display("FAIL lu_r0: got %b want 111100001", {w_vec, r_vec, pc_en}); end
        next_cycle();
        idexwsel = 5'd7; ifidrs = 5'd7; ifidrt = 5'd3;
        #1;
        compared++; if ({w_vec, r_vec, pc_en} !== 9'b0011_0100_0) begin mismatched++; $display("FAIL lu_rs: got %b want 001101000", {w_vec, r_vec, pc_en}); end
        next_cycle();
        idle();
        compared++; if (stall_cnt !== 32'd3) begin mismatched++; $display("FAIL lu_cnt: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_branch_priority();
        idle();
        exbranch = 1'b1; idexMemToReg = 1'b1; idexwsel = 5'd9; ifidrs = 5'd9; ihit = 1'b0;
        #1;
        compared++; if (r_vec !== 4'b1100) begin mismatched++; $display("FAIL br_rst: got %b want 1100", r_vec); end
        compared++; if (w_vec !== 4'b0011) begin mismatched++; $display("FAIL br_w: got %b want 0011", w_vec); end
        compared++; if (pc_en !== 1'b1) begin mismatched++; $display("FAIL br_pc_en: got %b want 1", pc_en); end
        next_cycle();
        idle();
    endtask

    task automatic test_imiss();
        idle();
        ihit = 1'b0;
        #1;
        compared++; if (w_vec !== 4'b0111) begin mismatched++; $display("FAIL imiss_w: got %b want 0111", w_vec); end
        compared++; if (r_vec !== 4'b1000) begin mismatched++; $display("FAIL imiss_rst: got %b want 1000", r_vec); end
        compared++; if ({pc_en, iREN} !== 2'b01) begin mismatched++; $display("FAIL imiss_pc_iren: got %b want 01", {pc_en, iREN}); end
        next_cycle();
        idle();
    endtask

    task automatic test_branch_in_dstall();
        idle();
        memcuDWE = 1'b1; exbranch = 1'b1;
        #1;
        compared++; if ({w_vec, r_vec, pc_en} !== 9'b0000_0000_0) begin mismatched++; $display("FAIL brds_stall: got %b want 000000000", {w_vec, r_vec, pc_en}); end
        next_cycle();
        dhit = 1'b1;
        #1;
        compared++; if ({w_vec, r_vec, pc_en} !== 9'b0011_1100_1) begin mismatched++; $display("FAIL brds_hit: got %b want 001111001", {w_vec, r_vec, pc_en}); end
        compared++; if (iREN !== 1'b0) begin mismatched++; $display("FAIL brds_iren: got %b want 0", iREN); end
        next_cycle();
        idle();
        compared++; if (stall_cnt !== 32'd4) begin mismatched++; $display("FAIL brds_cnt: got %0d want 4", stall_cnt); end
    endtask

    task automatic test_dwait_imiss();
        idle();
        memcuDRE = 1'b1;
        next_cycle();
        dhit = 1'b1; ihit = 1'b0;
        #1;
        compared++; if ({w_vec, r_vec, pc_en} !== 9'b0111_1000_0) begin mismatched++; $display("FAIL dwimiss: got %b want 011110000", {w_vec, r_vec, pc_en}); end
        next_cycle();
        idle();
        compared++; if (stall_cnt !== 32'd5) begin mismatched++; $display("FAIL dwimiss_cnt: got %0d want 5", stall_cnt); end
    endtask

    task automatic test_halt();
        idle();
        memcuHALT = 1'b1;
        #1;
        compared++; if ({w_vec, r_vec, pc_en, halt} !== 10'b0001_0000_00) begin mismatched++; $display("FAIL halt_final: got %b want 0001000000", {w_vec, r_vec, pc_en, halt}); end
        next_cycle();
        memcuHALT = 1'b0; exbranch = 1'b1; memcuDRE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            compared++; if ({w_vec, r_vec, pc_en, iREN, halt} !== 11'b0000_0000_001) begin mismatched++; $display("FAIL halted[%0d]: got %b want 00000000001", i, {w_vec, r_vec, pc_en, iREN, halt}); end
            next_cycle();
        end
        compared++; if (stall_cnt !== 32'd6) begin mismatched++; $display("FAIL halted_cnt: got %0d want 6", stall_cnt); end
        RST = 1'b1;
        idle();
        #1;
        compared++; if ({halt, r_vec} !== 5'b0_1111) begin mismatched++; $display("FAIL halt_rst: got %b want 01111", {halt, r_vec}); end
        next_cycle();
        RST = 1'b0;
        #1;
        compared++; if ({halt, w_vec, pc_en} !== 6'b0_1111_1) begin mismatched++; $display("FAIL halt_cleared: got %b want 011111", {halt, w_vec, pc_en}); end
        next_cycle();
    endtask

    task automatic test_reset_from_dwait();
        idle();
        memcuDRE = 1'b1;
        next_cycle();
        RST = 1'b1;
        #1;
        compared++; if ({w_vec, r_vec} !== 8'b0000_1111) begin mismatched++; $display("FAIL rstdw_during: got %b want 00001111", {w_vec, r_vec}); end
        next_cycle();
        RST = 1'b0;
        idle();
        #1;
        compared++; if ({w_vec, pc_en, iREN} !== 6'b1111_11) begin mismatched++; $display("FAIL rstdw_run: got %b want 111111", {w_vec, pc_en, iREN}); end
        compared++; if (stall_cnt !== 32'd0) begin mismatched++; $display("FAIL rstdw_cnt: got %0d want 0", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_saturation();
        idle();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        memcuDRE = 1'b1;
        repeat (20) next_cycle();
        compared++; if (s_stall_cnt !== 4'd15) begin mismatched++; $display("FAIL sat_cnt4: got %0d want 15", s_stall_cnt); end
        compared++; if (stall_cnt !== 32'd20) begin mismatched++; $display("FAIL sat_cnt32: got %0d want 20", stall_cnt); end
        dhit = 1'b1;
        next_cycle();
        idle();
        next_cycle();
        compared++; if (s_stall_cnt !== 4'd15) begin mismatched++; $display("FAIL sat_hold: got %0d want 15", s_stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_data_stall();
        test_load_use();
        test_branch_priority();
        test_imiss();
        test_branch_in_dstall();
        test_dwait_imiss();
        test_halt();
        test_reset_from_dwait();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
